// File: rtl/base_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Optional BASE_DIVIDER_ZERO_SHORTCUT_EN finishes a zero-divisor request one cycle after acceptance.
module base_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sr, prem, dsr;
    logic [WIDTH-1:0] sr_nxt, prem_nxt, res_q, res_r;
    logic             accept, step, last;
`ifdef BASE_DIVIDER_ZERO_SHORTCUT_EN
    logic             dz;
`endif

    // One restoring iteration; returns {next partial remainder, next shift register}.
    function automatic logic [2*WIDTH-1:0] trial_step(input logic [WIDTH-1:0] p,
                                                      input logic [WIDTH-1:0] s,
                                                      input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        logic           qbit;
        sh   = {p, s[WIDTH-1]};
        diff = sh - {1'b0, d};
        qbit = ~diff[WIDTH];
        return {(qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0]), s[WIDTH-2:0], qbit};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept             = (state == IDLE) && start;
        step               = (state == RUN);
        {prem_nxt, sr_nxt} = trial_step(prem, sr, dsr);
        res_q              = sr_nxt;
        res_r              = prem_nxt;
`ifdef BASE_DIVIDER_ZERO_SHORTCUT_EN
        last = step && ((cnt == CNT_W'(WIDTH - 1)) || dz);
        if (dz) begin
            res_q = '1;
            res_r = sr;
        end
`else
        last = step && (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    assign busy = (state == RUN);

    // Control and result registers; an aborted operation never reaches done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef BASE_DIVIDER_ZERO_SHORTCUT_EN
            dz          <= 1'b0;
`endif
        end else begin
            done <= last;
            if (accept) begin
                cnt <= '0;
`ifdef BASE_DIVIDER_ZERO_SHORTCUT_EN
                dz  <= (divisor == '0);
`endif
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                quotient    <= res_q;
                remainder   <= res_r;
                div_by_zero <= (dsr == '0);
            end
        end
    end

    // Datapath working registers are only meaningful inside RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            dsr  <= divisor;
            sr   <= dividend;
            prem <= '0;
        end else if (step) begin
            sr   <= sr_nxt;
            prem <= prem_nxt;
        end
    end

endmodule

// File: tb/tb_base_divider.sv
// Directed bench for base_divider at WIDTH=4: vector table plus busy-start, back-to-back and reset sequences.
module tb_base_divider;

    localparam int W = 4;
`ifdef BASE_DIVIDER_ZERO_SHORTCUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
        int lat;
    } vec_t;

    vec_t vecs[7];

    base_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for done at negedges; lat = edges after acceptance, -1 on timeout.
    task automatic wait_done(input int c0, output int lat, output int busyc);
        int cyc;
        bit got;
        cyc = c0; got = 0; busyc = c0;
        while (cyc < 20) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            cyc++;
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busyc++;
        end
        lat = got ? cyc - 1 : -1;
    endtask

    task automatic run_op(input int a, input int b, output int lat, output int busyc);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        wait_done(0, lat, busyc);
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int lat, busyc, pulses;
        vecs[0] = '{13, 3,  4, 1, 0, W};
        vecs[1] = '{15, 1, 15, 0, 0, W};
        vecs[2] = '{ 7, 9,  0, 7, 0, W};
        vecs[3] = '{ 0, 5,  0, 0, 0, W};
        vecs[4] = '{15, 15, 1, 0, 0, W};
        vecs[5] = '{ 9, 0, 15, 9, 1, ZLAT};
        vecs[6] = '{10, 4,  2, 2, 0, W};

        @(negedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, busyc);
            check($sformatf("v%0d_quotient", i), int'(quotient), vecs[i].q);
            check($sformatf("v%0d_remainder", i), int'(remainder), vecs[i].r);
            check($sformatf("v%0d_dbz", i), int'(div_by_zero), vecs[i].z);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), busyc, vecs[i].lat);
            check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), int'(done), 0);
            check($sformatf("v%0d_held_quotient", i), int'(quotient), vecs[i].q);
        end

        // start while busy must be ignored
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd6; divisor = 4'd2; start = 1'b1;
        wait_done(2, lat, busyc);
        check("busy_start_latency", lat, W);
        check("busy_start_quotient", int'(quotient), 4);
        check("busy_start_remainder", int'(remainder), 1);
        count_done(8, pulses);
        check("busy_start_no_extra_done", pulses, 0);
        check("busy_start_idle", int'(busy), 0);

        // re-issue in the done cycle
        run_op(13, 3, lat, busyc);
        check("b2b_first_quotient", int'(quotient), 4);
        dividend = 4'd6; divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted_busy", int'(busy), 1);
        check("b2b_held_quotient", int'(quotient), 4);
        check("b2b_held_remainder", int'(remainder), 1);
        wait_done(1, lat, busyc);
        check("b2b_latency", lat, W);
        check("b2b_quotient", int'(quotient), 3);
        check("b2b_remainder", int'(remainder), 0);

        // reset two cycles into an operation
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        count_done(8, pulses);
        check("midrst_no_done", pulses, 0);
        run_op(10, 4, lat, busyc);
        check("postrst_quotient", int'(quotient), 2);
        check("postrst_remainder", int'(remainder), 2);
        check("postrst_latency", lat, W);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
